// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage Zeptron pipeline: EX-stage operand forwarding,
// load-use and MDU scoreboard stalls, branch-flush arbitration and a
// saturating stall-cycle counter. Tracks a single outstanding MDU operation.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned RA_W        = $clog2(NUM_REGS),
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    // ID stage
    input  logic                   d_valid,
    input  logic [RA_W-1:0]        d_rs1,
    input  logic [RA_W-1:0]        d_rs2,
    input  logic [RA_W-1:0]        d_rd,
    input  logic                   d_uses_rs1,
    input  logic                   d_uses_rs2,
    input  logic                   d_reg_we,
    input  logic                   d_is_mdu,
    // EX stage
    input  logic [RA_W-1:0]        e_rs1,
    input  logic [RA_W-1:0]        e_rs2,
    input  logic [RA_W-1:0]        e_rd,
    input  logic                   e_reg_we,
    input  logic                   e_is_load,
    input  logic                   e_b_taken,
    // DM / WB stages
    input  logic [RA_W-1:0]        m_rd,
    input  logic                   m_reg_we,
    input  logic [RA_W-1:0]        w_rd,
    input  logic                   w_reg_we,
    // MDU completion
    input  logic                   mdu_done,
    // Outputs
    output logic [1:0]             forward_rrd1,
    output logic [1:0]             forward_rrd2,
    output logic                   stall_f,
    output logic                   stall_if_id,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   mdu_busy,
    output logic [RA_W-1:0]        mdu_rd,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] FwdRf  = 2'b00;
    localparam logic [1:0] FwdDm  = 2'b01;
    localparam logic [1:0] FwdWb  = 2'b10;
    localparam logic [1:0] FwdMdu = 2'b11;

    localparam logic [STALL_CNT_W-1:0] CntOne = STALL_CNT_W'(1);

    logic [NUM_REGS-1:0]    pending_q, pending_d;
    logic                   mdu_busy_q, mdu_busy_d;
    logic [RA_W-1:0]        mdu_rd_q, mdu_rd_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic                   done_clr;
    logic [NUM_REGS-1:0]    pending_eff;
    logic                   hit1, hit2;
    logic                   load_use, sb_raw, sb_waw, mdu_struct;
    logic                   stall;
    logic                   issue;

    // Youngest producer wins: DM before WB before the MDU result port.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic [RA_W-1:0] m_rd_a,
        input logic            m_we_a,
        input logic [RA_W-1:0] w_rd_a,
        input logic            w_we_a,
        input logic            done_a,
        input logic [RA_W-1:0] mdu_rd_a
    );
        logic [1:0] sel;
        sel = FwdRf;
        if (src == '0) begin
            sel = FwdRf;
        end else if (m_we_a && (m_rd_a == src)) begin
            sel = FwdDm;
        end else if (w_we_a && (w_rd_a == src)) begin
            sel = FwdWb;
        end else if (done_a && (mdu_rd_a == src)) begin
            sel = FwdMdu;
        end
        return sel;
    endfunction

    // Operand forwarding selects for the EX stage.
    always_comb begin
        forward_rrd1 = fwd_sel(e_rs1, m_rd, m_reg_we, w_rd, w_reg_we, mdu_done, mdu_rd_q);
        forward_rrd2 = fwd_sel(e_rs2, m_rd, m_reg_we, w_rd, w_reg_we, mdu_done, mdu_rd_q);
    end

    // Hazard detection; a completing MDU op no longer blocks its destination.
    always_comb begin
        done_clr    = mdu_done && mdu_busy_q;
        pending_eff = pending_q;
        if (done_clr) begin
            pending_eff[mdu_rd_q] = 1'b0;
        end
        hit1       = d_uses_rs1 && (d_rs1 != '0);
        hit2       = d_uses_rs2 && (d_rs2 != '0);
        load_use   = e_is_load && e_reg_we && (e_rd != '0) &&
                     ((hit1 && (d_rs1 == e_rd)) || (hit2 && (d_rs2 == e_rd)));
        sb_raw     = (hit1 && pending_eff[d_rs1]) || (hit2 && pending_eff[d_rs2]);
        sb_waw     = d_reg_we && (d_rd != '0) && pending_eff[d_rd];
        mdu_struct = d_is_mdu && mdu_busy_q && !mdu_done;
        // A taken branch makes the ID instruction wrong-path, so it never stalls.
        stall      = d_valid && (load_use || sb_raw || sb_waw || mdu_struct) && !e_b_taken;
        issue      = d_valid && d_is_mdu && !stall && !e_b_taken;
    end

    // Pipeline control outputs.
    always_comb begin
        stall_f      = stall;
        stall_if_id  = stall;
        flush_if_id  = e_b_taken;
        flush_id_ex  = e_b_taken || stall;
        mdu_busy     = mdu_busy_q;
        mdu_rd       = mdu_rd_q;
        stall_cycles = stall_cnt_q;
    end

    // Scoreboard next state: completion clears first, a same-cycle issue then sets.
    always_comb begin
        pending_d  = pending_q;
        mdu_busy_d = mdu_busy_q;
        mdu_rd_d   = mdu_rd_q;
        if (done_clr) begin
            pending_d[mdu_rd_q] = 1'b0;
            mdu_busy_d          = 1'b0;
        end
        if (issue) begin
            mdu_busy_d = 1'b1;
            mdu_rd_d   = d_rd;
            if (d_reg_we && (d_rd != '0)) begin
                pending_d[d_rd] = 1'b1;
            end
        end
    end

    // Saturating stall-cycle counter next state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            mdu_busy_q  <= 1'b0;
            mdu_rd_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            mdu_busy_q  <= mdu_busy_d;
            mdu_rd_q    <= mdu_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: forwarding vector table,
// directed multi-cycle sequences and randomized traffic against a
// reference model of the scoreboard rules.
module tb_hazard_scoreboard;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_valid, d_uses_rs1, d_uses_rs2, d_reg_we, d_is_mdu;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic [4:0] e_rs1, e_rs2, e_rd;
    logic       e_reg_we, e_is_load, e_b_taken;
    logic [4:0] m_rd, w_rd;
    logic       m_reg_we, w_reg_we, mdu_done;
    logic [1:0] forward_rrd1, forward_rrd2;
    logic       stall_f, stall_if_id, flush_if_id, flush_id_ex, mdu_busy;
    logic [4:0] mdu_rd;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .NUM_REGS   (32),
        .RA_W       (5),
        .STALL_CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_valid     (d_valid),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_rd        (d_rd),
        .d_uses_rs1  (d_uses_rs1),
        .d_uses_rs2  (d_uses_rs2),
        .d_reg_we    (d_reg_we),
        .d_is_mdu    (d_is_mdu),
        .e_rs1       (e_rs1),
        .e_rs2       (e_rs2),
        .e_rd        (e_rd),
        .e_reg_we    (e_reg_we),
        .e_is_load   (e_is_load),
        .e_b_taken   (e_b_taken),
        .m_rd        (m_rd),
        .m_reg_we    (m_reg_we),
        .w_rd        (w_rd),
        .w_reg_we    (w_reg_we),
        .mdu_done    (mdu_done),
        .forward_rrd1(forward_rrd1),
        .forward_rrd2(forward_rrd2),
        .stall_f     (stall_f),
        .stall_if_id (stall_if_id),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .mdu_busy    (mdu_busy),
        .mdu_rd      (mdu_rd),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        d_valid = 0; d_uses_rs1 = 0; d_uses_rs2 = 0; d_reg_we = 0; d_is_mdu = 0;
        d_rs1 = 0; d_rs2 = 0; d_rd = 0;
        e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_reg_we = 0; e_is_load = 0; e_b_taken = 0;
        m_rd = 0; m_reg_we = 0; w_rd = 0; w_reg_we = 0; mdu_done = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // ---------------- reference model ----------------
    bit m_pend[32];
    bit m_busy;
    int m_rdst;
    int m_cnt;

    function automatic int ref_fwd(int src);
        if (src == 0) return 0;
        if (m_reg_we && int'(m_rd) == src) return 1;
        if (w_reg_we && int'(w_rd) == src) return 2;
        if (mdu_done && m_rdst == src) return 3;
        return 0;
    endfunction

    // Register r blocks ID only if tracked and not being retired right now.
    function automatic bit blocked(int r);
        if (r == 0) return 0;
        return m_pend[r] && !(mdu_done && m_busy && m_rdst == r);
    endfunction

    function automatic bit ref_stall();
        bit h1, h2, lu, raw, waw, st;
        h1  = d_uses_rs1 && d_rs1 != 0;
        h2  = d_uses_rs2 && d_rs2 != 0;
        lu  = e_is_load && e_reg_we && e_rd != 0 &&
              ((h1 && d_rs1 == e_rd) || (h2 && d_rs2 == e_rd));
        raw = (h1 && blocked(int'(d_rs1))) || (h2 && blocked(int'(d_rs2)));
        waw = d_reg_we && blocked(int'(d_rd));
        st  = d_is_mdu && m_busy && !mdu_done;
        return d_valid && (lu || raw || waw || st) && !e_b_taken;
    endfunction

    task automatic model_commit(input bit stl);
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_busy = 0; m_rdst = 0; m_cnt = 0;
        end else begin
            if (mdu_done && m_busy) begin
                m_pend[m_rdst] = 0;
                m_busy = 0;
            end
            if (d_valid && d_is_mdu && !stl && !e_b_taken) begin
                m_busy = 1;
                m_rdst = int'(d_rd);
                if (d_reg_we && d_rd != 0) m_pend[int'(d_rd)] = 1;
            end
            if (stl && m_cnt < CMAX) m_cnt++;
        end
    endtask

    // ---------------- forwarding vectors ----------------
    typedef struct {
        logic [4:0] e_rs1, e_rs2, m_rd, w_rd;
        logic       m_we, w_we;
        logic [1:0] f1, f2;
    } fvec_t;

    fvec_t fv[6];

    initial begin
        bit stl;
        rst = 0;
        clear_inputs();

        fv[0] = '{5'd5,  5'd6,  5'd5,  5'd5, 1'b1, 1'b1, 2'b01, 2'b00};
        fv[1] = '{5'd5,  5'd6,  5'd5,  5'd5, 1'b0, 1'b1, 2'b10, 2'b00};
        fv[2] = '{5'd0,  5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 2'b00, 2'b00};
        fv[3] = '{5'd3,  5'd4,  5'd4,  5'd3, 1'b1, 1'b1, 2'b10, 2'b01};
        fv[4] = '{5'd3,  5'd3,  5'd3,  5'd3, 1'b0, 1'b0, 2'b00, 2'b00};
        fv[5] = '{5'd31, 5'd31, 5'd31, 5'd1, 1'b1, 1'b1, 2'b01, 2'b01};

        // Reset state
        do_reset();
        #3;
        check("rst_busy", int'(mdu_busy), 0);
        check("rst_rd", int'(mdu_rd), 0);
        check("rst_cnt", int'(stall_cycles), 0);
        check("rst_stall", int'(stall_f), 0);
        check("rst_flush", int'(flush_id_ex), 0);
        check("rst_fwd1", int'(forward_rrd1), 0);

        // Forwarding table
        for (int i = 0; i < 6; i++) begin
            tick();
            e_rs1 = fv[i].e_rs1; e_rs2 = fv[i].e_rs2;
            m_rd = fv[i].m_rd; m_reg_we = fv[i].m_we;
            w_rd = fv[i].w_rd; w_reg_we = fv[i].w_we;
            #3;
            check($sformatf("fwd1_v%0d", i), int'(forward_rrd1), int'(fv[i].f1));
            check($sformatf("fwd2_v%0d", i), int'(forward_rrd2), int'(fv[i].f2));
        end

        // Load-use
        do_reset();
        d_valid = 1; d_rs2 = 7; d_uses_rs2 = 1;
        e_is_load = 1; e_reg_we = 1; e_rd = 7;
        #3;
        check("lu_stall", int'(stall_f), 1);
        check("lu_stall_ifid", int'(stall_if_id), 1);
        check("lu_flush_idex", int'(flush_id_ex), 1);
        check("lu_flush_ifid", int'(flush_if_id), 0);
        tick();
        e_is_load = 0; e_reg_we = 0;
        #3;
        check("lu_release", int'(stall_f), 0);
        check("lu_cnt", int'(stall_cycles), 1);
        tick();
        e_is_load = 1; e_reg_we = 1; d_uses_rs2 = 0;
        #3;
        check("lu_unused_src", int'(stall_f), 0);

        // MDU RAW
        do_reset();
        d_valid = 1; d_is_mdu = 1; d_reg_we = 1; d_rd = 9;
        #3;
        check("raw_issue_nostall", int'(stall_f), 0);
        tick();
        check("raw_busy", int'(mdu_busy), 1);
        check("raw_rd", int'(mdu_rd), 9);
        d_is_mdu = 0; d_reg_we = 0; d_uses_rs1 = 1; d_rs1 = 9;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("raw_hold%0d", i), int'(stall_f), 1);
            tick();
        end
        mdu_done = 1;
        #3;
        check("raw_done_release", int'(stall_f), 0);
        tick();
        e_rs1 = 9;
        #3;
        check("raw_fwd_mdu", int'(forward_rrd1), 3);
        check("raw_busy_clr", int'(mdu_busy), 0);
        mdu_done = 0;
        #1;
        check("raw_pending_clr", int'(stall_f), 0);

        // Structural, back-to-back, branch override
        do_reset();
        d_valid = 1; d_is_mdu = 1; d_reg_we = 1; d_rd = 10;
        tick();
        d_rd = 11;
        #3;
        check("struct_stall", int'(stall_f), 1);
        tick();
        mdu_done = 1;
        #3;
        check("b2b_nostall", int'(stall_f), 0);
        tick();
        mdu_done = 0; d_is_mdu = 0; d_reg_we = 0;
        #3;
        check("b2b_busy", int'(mdu_busy), 1);
        check("b2b_rd", int'(mdu_rd), 11);
        d_uses_rs1 = 1; d_rs1 = 10;
        #1;
        check("b2b_old_clear", int'(stall_f), 0);
        d_rs1 = 11;
        #1;
        check("b2b_new_pend", int'(stall_f), 1);
        tick();
        e_b_taken = 1; d_is_mdu = 1; d_reg_we = 1; d_rd = 12;
        #3;
        check("br_stall", int'(stall_f), 0);
        check("br_flush_ifid", int'(flush_if_id), 1);
        check("br_flush_idex", int'(flush_id_ex), 1);
        tick();
        e_b_taken = 0; d_is_mdu = 0; d_reg_we = 0;
        #3;
        check("br_no_issue", int'(mdu_rd), 11);
        check("br_pend_kept", int'(stall_f), 1);

        // Saturation and reset mid-operation
        do_reset();
        d_valid = 1; d_is_mdu = 1; d_reg_we = 1; d_rd = 5;
        tick();
        d_is_mdu = 0; d_reg_we = 0;
        d_uses_rs2 = 1; d_rs2 = 7; e_is_load = 1; e_reg_we = 1; e_rd = 7;
        repeat (20) tick();
        check("sat_cnt", int'(stall_cycles), CMAX);
        check("sat_busy", int'(mdu_busy), 1);
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        check("mrst_busy", int'(mdu_busy), 0);
        check("mrst_rd", int'(mdu_rd), 0);
        check("mrst_cnt", int'(stall_cycles), 0);
        d_valid = 1; d_uses_rs1 = 1; d_rs1 = 5;
        #1;
        check("mrst_pend", int'(stall_f), 0);

        // Randomized traffic vs model
        do_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_busy = 0; m_rdst = 0; m_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            rst        = ($urandom_range(0, 99) == 0);
            d_valid    = ($urandom_range(0, 4) != 0);
            d_rs1      = 5'($urandom_range(0, 3));
            d_rs2      = 5'($urandom_range(0, 3));
            d_rd       = 5'($urandom_range(0, 3));
            d_uses_rs1 = 1'($urandom);
            d_uses_rs2 = 1'($urandom);
            d_reg_we   = 1'($urandom);
            d_is_mdu   = ($urandom_range(0, 2) == 0);
            e_rs1      = 5'($urandom_range(0, 3));
            e_rs2      = 5'($urandom_range(0, 3));
            e_rd       = 5'($urandom_range(0, 3));
            e_reg_we   = 1'($urandom);
            e_is_load  = ($urandom_range(0, 2) == 0);
            e_b_taken  = ($urandom_range(0, 5) == 0);
            m_rd       = 5'($urandom_range(0, 3));
            m_reg_we   = 1'($urandom);
            w_rd       = 5'($urandom_range(0, 3));
            w_reg_we   = 1'($urandom);
            mdu_done   = ($urandom_range(0, 3) == 0);
            #3;
            stl = ref_stall();
            check("rnd_fwd1", int'(forward_rrd1), ref_fwd(int'(e_rs1)));
            check("rnd_fwd2", int'(forward_rrd2), ref_fwd(int'(e_rs2)));
            check("rnd_stall_f", int'(stall_f), int'(stl));
            check("rnd_stall_ifid", int'(stall_if_id), int'(stl));
            check("rnd_flush_ifid", int'(flush_if_id), int'(e_b_taken));
            check("rnd_flush_idex", int'(flush_id_ex), int'(e_b_taken || stl));
            check("rnd_busy", int'(mdu_busy), int'(m_busy));
            check("rnd_rd", int'(mdu_rd), m_rdst);
            check("rnd_cnt", int'(stall_cycles), m_cnt);
            model_commit(stl);
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Next-generation hazard unit for the 5-stage Zeptron pipeline (IF/ID/EX/DM/WB). It keeps EX-stage forwarding for DM and WB, with the priority corrected so the youngest producer wins, and keeps the load-use stall. It adds three things: a register scoreboard for one outstanding variable-latency MDU (mul/div) op, with RAW/WAW/structural stalls and MDU-result forwarding; branch-flush arbitration; and a saturating stall-cycle counter.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never tracked
RA_W, 5, register address width, equal to $clog2(NUM_REGS)
STALL_CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
d_valid  in  1  ID holds a valid instruction
d_rs1, d_rs2, d_rd  in  RA_W each  ID source and destination registers
d_uses_rs1, d_uses_rs2  in  1 each  ID instruction reads rs1 / rs2
d_reg_we  in  1  ID instruction writes rd
d_is_mdu  in  1  ID instruction is an MDU op
e_rs1, e_rs2, e_rd  in  RA_W each  EX source and destination registers
e_reg_we, e_is_load  in  1 each  EX writes rd / EX is a load
e_b_taken  in  1  branch or jump resolved taken in EX
m_rd  in  RA_W  DM destination register
m_reg_we  in  1  DM writes rd
w_rd  in  RA_W  WB destination register
w_reg_we  in  1  WB writes rd
mdu_done  in  1  MDU result valid this cycle (one-cycle pulse)
forward_rrd1, forward_rrd2  out  2 each  operand source: 00 regfile, 01 DM, 10 WB, 11 MDU result
stall_f, stall_if_id  out  1 each  hold PC and IF/ID
flush_if_id, flush_id_ex  out  1 each  bubble insertion
mdu_busy  out  1  MDU op outstanding
mdu_rd  out  RA_W  destination of the outstanding MDU op; regfile write address on mdu_done
stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset, checked on the rising clk edge while rst=1:
  - pending[] = 0, mdu_busy = 0, mdu_rd = 0, stall_cycles = 0.
  - The combinational outputs then evaluate to 0 / 00, because the tracking state is clear.
- Forwarding (combinational, per operand Xn in {rs1, rs2}; first match wins):
  - e_Xn == 0: 00.
  - m_reg_we && m_rd == e_Xn: 01.
  - w_reg_we && w_rd == e_Xn: 10.
  - mdu_done && mdu_rd == e_Xn: 11.
  - Otherwise: 00.
- A source is "hit" only when its d_uses_* flag is set and the register is nonzero. Stall conditions, all qualified by d_valid:
  - load_use: e_is_load && e_reg_we && e_rd != 0 && (d_rs1 hit on e_rd || d_rs2 hit on e_rd).
  - sb_raw: pending[d_rs1] or pending[d_rs2] for a hit source, and not cleared by mdu_done this cycle for that register.
  - sb_waw: d_reg_we && d_rd != 0 && pending[d_rd], same mdu_done exemption.
  - mdu_struct: d_is_mdu && mdu_busy && !mdu_done.
  - stall = (load_use | sb_raw | sb_waw | mdu_struct) && !e_b_taken.
- Stall and flush outputs:
  - stall_f = stall_if_id = stall.
  - flush_if_id = e_b_taken.
  - flush_id_ex = e_b_taken | stall.
  - A taken branch overrides any stall, because the ID instruction is wrong-path.
- MDU issue (registered): issue = d_valid && d_is_mdu && !stall && !e_b_taken. On issue:
  - mdu_busy is set to 1 and mdu_rd to d_rd.
  - If d_reg_we && d_rd != 0, pending[d_rd] is set.
- MDU completion: on mdu_done, pending[mdu_rd] is cleared and mdu_busy is cleared.
  - If issue happens in the same cycle, the new op takes effect: busy stays 1, mdu_rd updates, and the new pending bit is set after the clear, so set wins when the two rds are equal.
  - mdu_done while !mdu_busy is ignored.
- An outstanding MDU op is older than any branch in EX, so e_b_taken never cancels it.
- At most one pending bit is set at any time.
- stall_cycles increments on every cycle with stall = 1 and saturates at all-ones (no wrap).
- rst asserted mid-operation discards the outstanding MDU tracking; the MDU is reset by the same rst.

Test Plan:
- Forward priority: e_rs1=5; m_rd=5, w_rd=5, both we=1 -> forward_rrd1=01. Drop m_reg_we -> 10. With e_rs1=0 and all matches -> 00.
- Load-use: EX holds a load with e_rd=7; ID reads rs2=7 with d_uses_rs2=1 -> stall=1 and flush_id_ex=1 for exactly 1 cycle, stall_cycles=1. With d_uses_rs2=0 -> no stall.
- MDU RAW: issue a div to x9, then ID reads x9 -> stall held until the mdu_done cycle. In that cycle stall=0 and, when that ID instruction reaches EX the following cycle while the same MDU result is still presented, forward=11. pending[9] clears, mdu_busy=0.
- Structural and back-to-back: a second MDU op while busy -> stall. A second MDU op on the same cycle as mdu_done -> issues, mdu_busy stays 1, and mdu_rd takes the new rd.
- Branch over stall: sb_raw stall active and e_b_taken=1 -> stall=0, flush_if_id=flush_id_ex=1, no issue, pending unchanged.
- Reset and saturation: with STALL_CNT_W=4, force 20 stall cycles -> counter holds at 15. Assert rst with mdu_busy=1 -> next cycle mdu_busy=0, pending all 0, counter 0.
